// File: rtl/dmem_arbiter.sv
// Two-requester DataMemory arbiter: fixed CPU priority with a starvation
// bound for the loader port, a registered accept stage that drives the
// memory for one cycle, and a registered per-port completion response.
module dmem_arbiter #(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  // CPU (MEM stage) port
  input  logic                 CpuReq,
  input  logic                 CpuWrite,
  input  logic [AddrWidth-1:0] CpuAddress,
  input  logic [DataWidth-1:0] CpuWriteData,
  output logic                 CpuGnt,
  output logic                 CpuStall,
  output logic                 CpuDone,
  output logic [DataWidth-1:0] CpuReadData,
  // Loader / debug port
  input  logic                 LdReq,
  input  logic                 LdWrite,
  input  logic [AddrWidth-1:0] LdAddress,
  input  logic [DataWidth-1:0] LdWriteData,
  output logic                 LdGnt,
  output logic                 LdDone,
  output logic [DataWidth-1:0] LdReadData,
  // DataMemory side
  output logic [AddrWidth-1:0] MemAddress,
  output logic [DataWidth-1:0] MemWriteData,
  output logic                 MemWrite,
  output logic                 MemRead,
  input  logic [DataWidth-1:0] MemReadData
);

  typedef enum logic {
    OwnerCpu = 1'b0,
    OwnerLd  = 1'b1
  } owner_e;

  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  logic [3:0]           starveCnt;
  logic                 ldWins;
  logic                 cpuWins;
  logic                 accValid;
  logic                 accWrite;
  owner_e               accOwner;
  logic [AddrWidth-1:0] accAddress;
  logic [DataWidth-1:0] accWriteData;

  // Arbitration: CPU first unless the loader has waited StarveLimit grants
  always_comb begin
    ldWins  = LdReq && (!CpuReq || (starveCnt == StarveMax));
    cpuWins = CpuReq && !ldWins;
  end

  assign LdGnt    = ldWins;
  assign CpuGnt   = cpuWins;
  assign CpuStall = CpuReq && !cpuWins;

  // Starvation counter: counts CPU wins while the loader is kept waiting
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      starveCnt <= '0;
    end else if (ldWins || !LdReq) begin
      starveCnt <= '0;
    end else if (cpuWins && (starveCnt != StarveMax)) begin
      starveCnt <= starveCnt + 4'd1;
    end
  end

  // Accept stage: latch the winning request for its single access cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      accValid     <= 1'b0;
      accWrite     <= 1'b0;
      accOwner     <= OwnerCpu;
      accAddress   <= '0;
      accWriteData <= '0;
    end else begin
      accValid <= ldWins || cpuWins;
      if (ldWins) begin
        accWrite     <= LdWrite;
        accOwner     <= OwnerLd;
        accAddress   <= LdAddress;
        accWriteData <= LdWriteData;
      end else if (cpuWins) begin
        accWrite     <= CpuWrite;
        accOwner     <= OwnerCpu;
        accAddress   <= CpuAddress;
        accWriteData <= CpuWriteData;
      end
    end
  end

  // Access stage: memory strobes only during a valid access cycle
  always_comb begin
    MemWrite     = accValid && accWrite;
    MemRead      = accValid && !accWrite;
    MemAddress   = accValid ? accAddress : '0;
    MemWriteData = accValid ? accWriteData : '0;
  end

  // Response: one-cycle Done to the owner, read data captured on reads
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      CpuDone     <= 1'b0;
      LdDone      <= 1'b0;
      CpuReadData <= '0;
      LdReadData  <= '0;
    end else begin
      CpuDone <= accValid && (accOwner == OwnerCpu);
      LdDone  <= accValid && (accOwner == OwnerLd);
      if (accValid && !accWrite) begin
        if (accOwner == OwnerCpu) begin
          CpuReadData <= MemReadData;
        end else begin
          LdReadData <= MemReadData;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level model (grant rule, in-order
// access schedule, reference memory) checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_dmem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          CpuReq, CpuWrite;
  logic [AW-1:0] CpuAddress;
  logic [DW-1:0] CpuWriteData;
  logic          CpuGnt, CpuStall, CpuDone;
  logic [DW-1:0] CpuReadData;
  logic          LdReq, LdWrite;
  logic [AW-1:0] LdAddress;
  logic [DW-1:0] LdWriteData;
  logic          LdGnt, LdDone;
  logic [DW-1:0] LdReadData;
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemWriteData, MemReadData;
  logic          MemWrite, MemRead;

  int tests = 0;
  int fails = 0;

  dmem_arbiter #(.AddrWidth(AW), .DataWidth(DW), .StarveLimit(SL)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .CpuReq(CpuReq), .CpuWrite(CpuWrite), .CpuAddress(CpuAddress),
    .CpuWriteData(CpuWriteData), .CpuGnt(CpuGnt), .CpuStall(CpuStall),
    .CpuDone(CpuDone), .CpuReadData(CpuReadData),
    .LdReq(LdReq), .LdWrite(LdWrite), .LdAddress(LdAddress),
    .LdWriteData(LdWriteData), .LdGnt(LdGnt), .LdDone(LdDone),
    .LdReadData(LdReadData),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
  );

  always #5 Clk = ~Clk;

  // DataMemory stand-in: combinational read, write at the end of the cycle
  logic [DW-1:0] tbMem [0:255];
  initial for (int i = 0; i < 256; i++) tbMem[i] = '0;
  always @(posedge Clk) if (MemWrite) tbMem[MemAddress[7:0]] <= MemWriteData;
  assign MemReadData = tbMem[MemAddress[7:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: a grant at cycle n is an access at n+1, Done at n+2
  typedef struct { bit ld; bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; } acc_t;
  typedef struct { bit ld; bit rd; logic [DW-1:0] data; } done_t;
  acc_t          accQ [int];
  done_t         doneQ [int];
  logic [DW-1:0] modelMem [logic [AW-1:0]];
  logic [DW-1:0] expCpuRd = '0;
  logic [DW-1:0] expLdRd  = '0;
  int            waitCnt  = 0;
  int            mcyc     = 0;

  always @(negedge Clk) begin
    bit            eLd, eCpu, eCpuDone, eLdDone;
    acc_t          a;
    done_t         d;
    logic [DW-1:0] v;
    mcyc++;
    if (!Reset_n) begin
      accQ.delete();
      doneQ.delete();
      expCpuRd = '0;
      expLdRd  = '0;
      waitCnt  = 0;
      chk("rst MemWrite", MemWrite, 0);
      chk("rst MemRead", MemRead, 0);
      chk("rst MemAddress", MemAddress, 0);
      chk("rst MemWriteData", MemWriteData, 0);
      chk("rst CpuDone", CpuDone, 0);
      chk("rst LdDone", LdDone, 0);
      chk("rst CpuReadData", CpuReadData, 0);
      chk("rst LdReadData", LdReadData, 0);
    end else begin
      eLd  = LdReq && (!CpuReq || waitCnt >= int'(SL));
      eCpu = CpuReq && !eLd;
      chk("model LdGnt", LdGnt, eLd);
      chk("model CpuGnt", CpuGnt, eCpu);
      chk("model CpuStall", CpuStall, CpuReq && !eCpu);
      if (accQ.exists(mcyc)) begin
        a = accQ[mcyc];
        accQ.delete(mcyc);
        v = '0;
        chk("model MemWrite", MemWrite, a.wr);
        chk("model MemRead", MemRead, !a.wr);
        chk("model MemAddress", MemAddress, a.addr);
        chk("model MemWriteData", MemWriteData, a.data);
        if (a.wr) modelMem[a.addr] = a.data;
        else if (modelMem.exists(a.addr)) v = modelMem[a.addr];
        doneQ[mcyc + 1] = '{ld: a.ld, rd: !a.wr, data: v};
      end else begin
        chk("model idle MemWrite", MemWrite, 0);
        chk("model idle MemRead", MemRead, 0);
        chk("model idle MemAddress", MemAddress, 0);
        chk("model idle MemWriteData", MemWriteData, 0);
      end
      eCpuDone = 0;
      eLdDone  = 0;
      if (doneQ.exists(mcyc)) begin
        d = doneQ[mcyc];
        doneQ.delete(mcyc);
        if (d.ld) begin
          eLdDone = 1;
          if (d.rd) expLdRd = d.data;
        end else begin
          eCpuDone = 1;
          if (d.rd) expCpuRd = d.data;
        end
      end
      chk("model CpuDone", CpuDone, eCpuDone);
      chk("model LdDone", LdDone, eLdDone);
      chk("model CpuReadData", CpuReadData, expCpuRd);
      chk("model LdReadData", LdReadData, expLdRd);
      if (eLd) accQ[mcyc + 1] = '{ld: 1'b1, wr: LdWrite, addr: LdAddress, data: LdWriteData};
      else if (eCpu) accQ[mcyc + 1] = '{ld: 1'b0, wr: CpuWrite, addr: CpuAddress, data: CpuWriteData};
      if (eLd || !LdReq) waitCnt = 0;
      else if (eCpu && waitCnt < int'(SL)) waitCnt++;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic waitCpuDone(input string name);
    int n = 0;
    @(negedge Clk);
    while (!CpuDone && n < 8) begin
      tick();
      @(negedge Clk);
      n++;
    end
    chk({name, " done seen"}, CpuDone, 1);
  endtask

  // Directed scenarios
  initial begin
    bit [9:0] cg, lg, st;
    int       ldDones, cpuDones;
    bit       sawDone;
    Reset_n = 1'b0;
    CpuReq = 0; CpuWrite = 0; CpuAddress = '0; CpuWriteData = '0;
    LdReq = 0;  LdWrite = 0;  LdAddress = '0;  LdWriteData = '0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (4) tick();

    // CPU write 3321 to 50, then read 50
    CpuReq = 1; CpuWrite = 1; CpuAddress = 50; CpuWriteData = 3321;
    @(negedge Clk); chk("wr CpuGnt", CpuGnt, 1);
    tick();
    CpuWrite = 0; CpuWriteData = '0;
    @(negedge Clk);
    chk("wr MemWrite", MemWrite, 1);
    chk("wr MemAddress", MemAddress, 50);
    chk("wr MemWriteData", MemWriteData, 3321);
    chk("rd CpuGnt", CpuGnt, 1);
    tick();
    CpuReq = 0;
    @(negedge Clk);
    chk("wr CpuDone", CpuDone, 1);
    chk("rd MemRead", MemRead, 1);
    tick();
    @(negedge Clk);
    chk("rd CpuDone", CpuDone, 1);
    chk("rd CpuReadData", CpuReadData, 3321);
    tick();

    // Loader only: write 5 to 50, read it back
    LdReq = 1; LdWrite = 1; LdAddress = 50; LdWriteData = 5;
    tick();
    LdWrite = 0; LdWriteData = '0;
    tick();
    LdReq = 0;
    ldDones = 0; cpuDones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      ldDones += int'(LdDone);
      cpuDones += int'(CpuDone);
      tick();
    end
    chk("ld LdDone count", ldDones, 2);
    chk("ld CpuDone count", cpuDones, 0);
    chk("ld LdReadData", LdReadData, 5);

    // Starvation bound with continuous CPU reads
    LdReq = 1; LdWrite = 0; LdAddress = 60;
    CpuReq = 1; CpuWrite = 0; CpuAddress = 100;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      cg[i] = CpuGnt; lg[i] = LdGnt; st[i] = CpuStall;
      tick();
      if (lg[i]) LdReq = 0;
      CpuAddress = AW'(101 + i);
    end
    CpuReq = 0;
    chk("starve CpuGnt pattern", cg, 10'b1111101111);
    chk("starve LdGnt pattern", lg, 10'b0000010000);
    chk("starve CpuStall pattern", st, 10'b0000010000);
    repeat (3) tick();

    // Ordering: LD write 7 to 8, CPU read 8 on the next cycle
    LdReq = 1; LdWrite = 1; LdAddress = 8; LdWriteData = 7;
    tick();
    LdReq = 0; LdWrite = 0; LdWriteData = '0;
    CpuReq = 1; CpuWrite = 0; CpuAddress = 8;
    tick();
    CpuReq = 0;
    waitCpuDone("order");
    chk("order CpuReadData", CpuReadData, 7);
    repeat (2) tick();

    // Reset during the access cycle of a CPU write of 9 to 12
    CpuReq = 1; CpuWrite = 1; CpuAddress = 12; CpuWriteData = 9;
    tick();
    CpuReq = 0; CpuWrite = 0; CpuWriteData = '0;
    #2;
    chk("abort MemWrite before reset", MemWrite, 1);
    Reset_n = 1'b0;
    #1;
    chk("abort MemWrite async drop", MemWrite, 0);
    chk("abort MemAddress async", MemAddress, 0);
    chk("abort CpuReadData cleared", CpuReadData, 0);
    sawDone = 0;
    @(negedge Clk); sawDone |= CpuDone;
    tick();
    @(negedge Clk); sawDone |= CpuDone;
    tick();
    Reset_n = 1'b1;
    @(negedge Clk); sawDone |= CpuDone;
    tick();
    chk("abort no CpuDone", sawDone, 0);
    CpuReq = 1; CpuWrite = 0; CpuAddress = 12;
    tick();
    CpuReq = 0;
    waitCpuDone("abort readback");
    chk("abort readback CpuReadData", CpuReadData, 0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
